// File: rtl/strobe_capture_pkg.sv
// Shared types and constants for the strobe capture bank.
// Imported by the per-channel cell and the top-level bank.
package strobe_capture_pkg;

  typedef enum logic {
    MODE_LEVEL = 1'b0,
    MODE_EDGE  = 1'b1
  } cap_mode_e;

  // All ones after reset so a strobe already high at release is not an edge
  localparam logic CTL_RST = 1'b1;

endpackage

// File: rtl/strobe_capture_cell.sv
// One storage channel: either a registered level-sensitive latch or a rising-strobe capture
// register, with a one-cycle capture pulse and a saturating capture counter.
module strobe_capture_cell
  import strobe_capture_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  cap_mode_e        mode_i,
  input  logic             ctl_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             clr_cnt_i,
  output logic [WIDTH-1:0] q_o,
  output logic             cap_pulse_o,
  output logic [CNT_W-1:0] cap_cnt_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] q_q, q_d;
  logic             ctl_q, ctl_d;
  logic             pulse_q, pulse_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_evt;
  logic             edge_evt;
  logic             evt;

  // Level mode only counts a refresh that actually changes the stored value
  assign level_evt = !ctl_i && (data_i != q_q);
  assign edge_evt  = ctl_i && !ctl_q;
  assign evt       = (mode_i == MODE_EDGE) ? edge_evt : level_evt;

  always_comb begin
    q_d     = q_q;
    ctl_d   = ctl_i;
    pulse_d = evt;
    cnt_d   = cnt_q;
    if (evt) begin
      q_d = data_i;
    end
    // Clear wins over a coincident event; the data still moves
    if (clr_cnt_i) begin
      cnt_d = '0;
    end else if (evt && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q     <= '0;
      ctl_q   <= CTL_RST;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q_q     <= q_d;
      ctl_q   <= ctl_d;
      pulse_q <= pulse_d;
      cnt_q   <= cnt_d;
    end
  end

  assign q_o         = q_q;
  assign cap_pulse_o = pulse_q;
  assign cap_cnt_o   = cnt_q;

endmodule

// File: rtl/strobe_capture_bank.sv
// Bank of CHANNELS independent capture cells; unpacks the flat input buses per channel
// and repacks q, pulse and count outputs with channel c at [c*W +: W].
module strobe_capture_bank
  import strobe_capture_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int CNT_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS-1:0]       mode_i,
  input  logic [CHANNELS-1:0]       ctl_i,
  input  logic [CHANNELS*WIDTH-1:0] data_i,
  input  logic                      clr_cnt_i,
  output logic [CHANNELS*WIDTH-1:0] q_o,
  output logic [CHANNELS-1:0]       cap_pulse_o,
  output logic [CHANNELS*CNT_W-1:0] cap_cnt_o
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    strobe_capture_cell #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_cell (
      .clk         (clk),
      .rst_n       (rst_n),
      .mode_i      (cap_mode_e'(mode_i[c])),
      .ctl_i       (ctl_i[c]),
      .data_i      (data_i[c*WIDTH +: WIDTH]),
      .clr_cnt_i   (clr_cnt_i),
      .q_o         (q_o[c*WIDTH +: WIDTH]),
      .cap_pulse_o (cap_pulse_o[c]),
      .cap_cnt_o   (cap_cnt_o[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_strobe_capture_bank.sv
// Directed plus randomized bench for strobe_capture_bank, checked against an array-based
// model of the capture rules (CNT_W=2 so saturation is reachable quickly).
module tb_strobe_capture_bank;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int CW = 2;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   mode_i;
  logic [CH-1:0]   ctl_i;
  logic [CH*W-1:0] data_i;
  logic            clr_cnt_i;
  logic [CH*W-1:0] q_o;
  logic [CH-1:0]   cap_pulse_o;
  logic [CH*CW-1:0] cap_cnt_o;

  logic [W-1:0] data_a[CH];

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // reference state
  int      m_q[CH];
  int      m_cnt[CH];
  bit      m_ctl[CH];
  bit [CH-1:0] m_pulse;

  strobe_capture_bank #(
    .WIDTH    (W),
    .CHANNELS (CH),
    .CNT_W    (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mode_i      (mode_i),
    .ctl_i       (ctl_i),
    .data_i      (data_i),
    .clr_cnt_i   (clr_cnt_i),
    .q_o         (q_o),
    .cap_pulse_o (cap_pulse_o),
    .cap_cnt_o   (cap_cnt_o)
  );

  for (genvar c = 0; c < CH; c++) begin : g_pack
    assign data_i[c*W +: W] = data_a[c];
  end

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_q[c]   = 0;
      m_cnt[c] = 0;
      m_ctl[c] = 1'b1;
    end
    m_pulse = '0;
  endtask

  // Applies one clock edge of the capture rules to the model
  task automatic model_edge();
    bit ev;
    for (int c = 0; c < CH; c++) begin
      if (mode_i[c]) ev = ctl_i[c] && !m_ctl[c];
      else           ev = !ctl_i[c] && (int'(data_a[c]) != m_q[c]);
      m_pulse[c] = ev;
      if (ev) m_q[c] = int'(data_a[c]);
      if (clr_cnt_i)                   m_cnt[c] = 0;
      else if (ev && m_cnt[c] < CNT_MAX) m_cnt[c] = m_cnt[c] + 1;
      m_ctl[c] = ctl_i[c];
    end
  endtask

  task automatic check_all(input string where);
    chk({where, ":pulse"}, 32'(cap_pulse_o), 32'(m_pulse));
    for (int c = 0; c < CH; c++) begin
      chk($sformatf("%s:q%0d", where, c),   32'(q_o[c*W +: W]),        m_q[c]);
      chk($sformatf("%s:cnt%0d", where, c), 32'(cap_cnt_o[c*CW +: CW]), m_cnt[c]);
    end
  endtask

  // driver: inputs are already set by the caller; take one edge and compare
  task automatic step(input string where);
    @(posedge clk);
    model_edge();
    #1;
    check_all(where);
  endtask

  initial begin
    rst_n     = 1'b0;
    mode_i    = '0;
    ctl_i     = '1;
    clr_cnt_i = 1'b0;
    for (int c = 0; c < CH; c++) data_a[c] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("rst");
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");

    // level mode, channel 0
    ctl_i[0] = 1'b0; data_a[0] = 8'h11; step("lvl11");
    chk("lvl_q11", 32'(q_o[7:0]), 32'h11);
    data_a[0] = 8'h22; step("lvl22");
    data_a[0] = 8'h22; step("lvl22b");
    chk("lvl_nopulse", 32'(cap_pulse_o[0]), 0);
    ctl_i[0] = 1'b1; data_a[0] = 8'h33; step("lvlhold");
    chk("lvl_q_hold", 32'(q_o[7:0]), 32'h22);
    chk("lvl_cnt2", 32'(cap_cnt_o[1:0]), 2);

    // load A5 then reset mid-run, checked before the next edge
    ctl_i[0] = 1'b0; data_a[0] = 8'hA5; step("a5");
    ctl_i[0] = 1'b1; step("a5hold");
    chk("a5_q", 32'(q_o[7:0]), 32'hA5);
    #3;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_q",     32'(q_o), 0);
    chk("async_pulse", 32'(cap_pulse_o), 0);
    chk("async_cnt",   32'(cap_cnt_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    step("release");
    chk("release_nopulse", 32'(cap_pulse_o), 0);

    // edge mode, channel 1: held strobe captures once
    mode_i[1] = 1'b1; ctl_i[1] = 1'b0; step("e_lo");
    ctl_i[1] = 1'b1; data_a[1] = 8'h5A; step("e_rise");
    chk("e_q5a", 32'(q_o[15:8]), 32'h5A);
    data_a[1] = 8'h00; step("e_hold1");
    step("e_hold2");
    ctl_i[1] = 1'b0; step("e_fall");
    chk("e_q_still", 32'(q_o[15:8]), 32'h5A);
    chk("e_cnt1", 32'(cap_cnt_o[3:2]), 1);

    // mode switch with strobe already high: no capture
    mode_i[2] = 1'b0; ctl_i[2] = 1'b1; data_a[2] = 8'h44; step("sw_lvl");
    mode_i[2] = 1'b1; step("sw_edge");
    chk("sw_nocap", 32'(cap_pulse_o[2]), 0);
    ctl_i[2] = 1'b0; step("sw_lo");
    ctl_i[2] = 1'b1; data_a[2] = 8'h7E; step("sw_rise");
    chk("sw_q7e", 32'(q_o[23:16]), 32'h7E);

    // saturation then clear beating a coincident capture, channel 3
    mode_i[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ctl_i[3] = 1'b0; step("sat_lo");
      ctl_i[3] = 1'b1; data_a[3] = 8'(i); step("sat_rise");
    end
    chk("sat_cnt3", 32'(cap_cnt_o[7:6]), CNT_MAX);
    ctl_i[3] = 1'b0; step("clr_lo");
    ctl_i[3] = 1'b1; data_a[3] = 8'hC3; clr_cnt_i = 1'b1; step("clr_rise");
    chk("clr_cnt0", 32'(cap_cnt_o[7:6]), 0);
    chk("clr_q",    32'(q_o[31:24]), 32'hC3);
    chk("clr_pulse", 32'(cap_pulse_o[3]), 1);
    clr_cnt_i = 1'b0;

    // all channels strobed together
    mode_i = '1; ctl_i = '0; step("all_lo");
    ctl_i = '1;
    for (int c = 0; c < CH; c++) data_a[c] = 8'(c + 1);
    step("all_rise");
    chk("all_pulse", 32'(cap_pulse_o), 32'hF);
    chk("all_q", 32'(q_o), 32'h04030201);

    // randomized traffic; narrow data range makes equal-value refreshes common
    for (int i = 0; i < 400; i++) begin
      mode_i    = CH'($urandom_range(0, (1 << CH) - 1));
      ctl_i     = CH'($urandom_range(0, (1 << CH) - 1));
      clr_cnt_i = ($urandom_range(0, 15) == 0);
      for (int c = 0; c < CH; c++) data_a[c] = 8'($urandom_range(0, 3));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
